// File: rtl/lsu_violation_arbiter.sv
// lsu_violation_arbiter: picks the oldest memory-order violation reported by the
// LSU channels, holds it in a single pending slot and presents it to the
// front end and ROB with a valid/ready handshake. Reports that an older
// violation or an external flush makes redundant are dropped.
// Optional build macro LSU_VIOL_STATS_EN adds saturating issue/drop counters.
module lsu_violation_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ROB_TAG_W = 6,
  parameter int PC_W      = 32,
  parameter int BHSR_W    = 8,
  parameter int SSIT_W    = 10,
  parameter int LFST_W    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          viol_valid_i,
  input  logic [NUM_PORTS-1:0]          viol_device_i,
  input  logic [NUM_PORTS*ROB_TAG_W-1:0] viol_rob_tag_i,
  input  logic [NUM_PORTS*PC_W-1:0]     viol_pc_i,
  input  logic [NUM_PORTS*BHSR_W-1:0]   viol_bhsr_i,
  input  logic [NUM_PORTS*SSIT_W-1:0]   viol_load_pc_i,
  input  logic [NUM_PORTS*SSIT_W-1:0]   viol_store_pc_i,
  input  logic [NUM_PORTS*LFST_W-1:0]   viol_load_id_i,
  input  logic [NUM_PORTS*LFST_W-1:0]   viol_store_id_i,
  input  logic [ROB_TAG_W-1:0]          rob_head_i,
  input  logic                          ext_flush_i,
  input  logic [ROB_TAG_W-1:0]          ext_flush_tag_i,
  input  logic                          redirect_ready_i,
  output logic                          store_set_violation_o,
  output logic                          device_violation_o,
  output logic [ROB_TAG_W-1:0]          store_set_rob_tag_o,
  output logic [PC_W-1:0]               violation_pc_o,
  output logic [BHSR_W-1:0]             violation_bhsr_o,
  output logic [SSIT_W-1:0]             violation_load_pc_o,
  output logic [SSIT_W-1:0]             violation_store_pc_o,
  output logic [LFST_W-1:0]             violation_load_id_o,
  output logic [LFST_W-1:0]             violation_store_id_o
`ifdef LSU_VIOL_STATS_EN
  ,
  output logic [31:0]                   viol_issue_cnt_o,
  output logic [31:0]                   viol_drop_cnt_o
`endif
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef struct packed {
    logic [ROB_TAG_W-1:0] tag;
    logic [PC_W-1:0]      pc;
    logic [BHSR_W-1:0]    bhsr;
    logic [SSIT_W-1:0]    load_pc;
    logic [SSIT_W-1:0]    store_pc;
    logic [LFST_W-1:0]    load_id;
    logic [LFST_W-1:0]    store_id;
  } viol_t;

  // Store-set and device flags are kept as separate flops so both outputs come
  // straight from registers; the slot is valid when either is set.
  logic                 ss_q, ss_d, dev_q, dev_d;
  viol_t                entry_q, entry_d;
  logic                 pend_valid;
  logic [ROB_TAG_W-1:0] pend_age, flush_age, cand_age;
  logic [IDX_W-1:0]     cand_idx;
  logic                 cand_valid, cand_device, cand_keep, pend_keep;
  logic                 issue, capture;
  viol_t                cand_entry;

  assign pend_valid = ss_q | dev_q;
  assign pend_age   = entry_q.tag - rob_head_i;
  assign flush_age  = ext_flush_tag_i - rob_head_i;
  assign issue      = pend_valid & redirect_ready_i;

  // Oldest valid report across the ports; scanning upward with a strict compare
  // makes the lowest port win an age tie.
  always_comb begin : cand_sel
    logic [ROB_TAG_W-1:0] port_age;
    port_age   = '0;
    cand_valid = 1'b0;
    cand_idx   = '0;
    cand_age   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_age = viol_rob_tag_i[p*ROB_TAG_W +: ROB_TAG_W] - rob_head_i;
      if (viol_valid_i[p] && (!cand_valid || port_age < cand_age)) begin
        cand_valid = 1'b1;
        cand_idx   = IDX_W'(p);
        cand_age   = port_age;
      end
    end
  end

  // Payload of the winning port.
  always_comb begin
    cand_device         = viol_device_i[cand_idx];
    cand_entry.tag      = viol_rob_tag_i[cand_idx*ROB_TAG_W +: ROB_TAG_W];
    cand_entry.pc       = viol_pc_i[cand_idx*PC_W +: PC_W];
    cand_entry.bhsr     = viol_bhsr_i[cand_idx*BHSR_W +: BHSR_W];
    cand_entry.load_pc  = viol_load_pc_i[cand_idx*SSIT_W +: SSIT_W];
    cand_entry.store_pc = viol_store_pc_i[cand_idx*SSIT_W +: SSIT_W];
    cand_entry.load_id  = viol_load_id_i[cand_idx*LFST_W +: LFST_W];
    cand_entry.store_id = viol_store_id_i[cand_idx*LFST_W +: LFST_W];
  end

  // Flush filter and next-slot decision. An issue uses the unfiltered pending
  // valid, so an accept wins over a same-cycle flush of the pending entry.
  always_comb begin
    cand_keep = cand_valid & ~(ext_flush_i & (cand_age > flush_age));
    pend_keep = pend_valid & ~(ext_flush_i & (pend_age > flush_age));
    if (issue) begin
      capture = cand_keep & (cand_age < pend_age);
    end else begin
      capture = cand_keep & (~pend_keep | (cand_age < pend_age));
    end
    ss_d    = 1'b0;
    dev_d   = 1'b0;
    entry_d = '0;
    if (capture) begin
      ss_d    = ~cand_device;
      dev_d   = cand_device;
      entry_d = cand_entry;
    end else if (!issue && pend_keep) begin
      ss_d    = ss_q;
      dev_d   = dev_q;
      entry_d = entry_q;
    end
  end

  // Pending slot register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_q    <= 1'b0;
      dev_q   <= 1'b0;
      entry_q <= '0;
    end else begin
      ss_q    <= ss_d;
      dev_q   <= dev_d;
      entry_q <= entry_d;
    end
  end

  assign store_set_violation_o = ss_q;
  assign device_violation_o    = dev_q;
  assign store_set_rob_tag_o   = entry_q.tag;
  assign violation_pc_o        = entry_q.pc;
  assign violation_bhsr_o      = entry_q.bhsr;
  assign violation_load_pc_o   = entry_q.load_pc;
  assign violation_store_pc_o  = entry_q.store_pc;
  assign violation_load_id_o   = entry_q.load_id;
  assign violation_store_id_o  = entry_q.store_id;

`ifdef LSU_VIOL_STATS_EN
  logic [31:0]          issue_cnt_q, issue_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [NUM_PORTS-1:0] other_valid;
  logic                 dropped;

  // A cycle drops something when a non-winning port is valid or the winner
  // itself is not captured.
  always_comb begin
    other_valid = viol_valid_i & ~(NUM_PORTS'(1) << cand_idx);
    dropped     = (|other_valid) | (cand_valid & ~capture);
    issue_cnt_d = issue_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (issue && issue_cnt_q != '1) issue_cnt_d = issue_cnt_q + 32'd1;
    if (dropped && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 32'd1;
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign viol_issue_cnt_o = issue_cnt_q;
  assign viol_drop_cnt_o  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_lsu_violation_arbiter.sv
// Directed bench for lsu_violation_arbiter (NUM_PORTS=2, ROB_TAG_W=6).
// Per-port payload fields are derived from the refetch PC so one expected PC
// determines every expected payload field.
module tb_lsu_violation_arbiter;
  localparam int NP = 2;
  localparam int TW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NP-1:0] v_valid = '0, v_dev = '0;
  logic [NP*TW-1:0] v_tag = '0;
  logic [NP*32-1:0] v_pc = '0;
  logic [NP*8-1:0]  v_bhsr = '0;
  logic [NP*10-1:0] v_lpc = '0, v_spc = '0;
  logic [NP*4-1:0]  v_lid = '0, v_sid = '0;
  logic [TW-1:0] head = '0, flush_tag = '0;
  logic          flush = 1'b0, ready = 1'b0;

  logic          ss_o, dev_o;
  logic [TW-1:0] tag_o;
  logic [31:0]   pc_o;
  logic [7:0]    bhsr_o;
  logic [9:0]    lpc_o, spc_o;
  logic [3:0]    lid_o, sid_o;

  int n_cmp = 0;
  int n_bad = 0;

  lsu_violation_arbiter #(.NUM_PORTS(NP), .ROB_TAG_W(TW), .PC_W(32), .BHSR_W(8),
                          .SSIT_W(10), .LFST_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .viol_valid_i(v_valid), .viol_device_i(v_dev), .viol_rob_tag_i(v_tag),
    .viol_pc_i(v_pc), .viol_bhsr_i(v_bhsr),
    .viol_load_pc_i(v_lpc), .viol_store_pc_i(v_spc),
    .viol_load_id_i(v_lid), .viol_store_id_i(v_sid),
    .rob_head_i(head), .ext_flush_i(flush), .ext_flush_tag_i(flush_tag),
    .redirect_ready_i(ready),
    .store_set_violation_o(ss_o), .device_violation_o(dev_o),
    .store_set_rob_tag_o(tag_o), .violation_pc_o(pc_o), .violation_bhsr_o(bhsr_o),
    .violation_load_pc_o(lpc_o), .violation_store_pc_o(spc_o),
    .violation_load_id_o(lid_o), .violation_store_id_o(sid_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic ss, input logic dv,
                            input logic [TW-1:0] t, input logic [31:0] pc);
    check_eq({tag, ".ss"},   64'(ss_o),   64'(ss));
    check_eq({tag, ".dev"},  64'(dev_o),  64'(dv));
    check_eq({tag, ".tag"},  64'(tag_o),  64'(t));
    check_eq({tag, ".pc"},   64'(pc_o),   64'(pc));
    check_eq({tag, ".bhsr"}, 64'(bhsr_o), 64'(pc[15:8]));
    check_eq({tag, ".lpc"},  64'(lpc_o),  64'(pc[9:0]));
    check_eq({tag, ".spc"},  64'(spc_o),  64'(pc[19:10]));
    check_eq({tag, ".lid"},  64'(lid_o),  64'(pc[3:0]));
    check_eq({tag, ".sid"},  64'(sid_o),  64'(pc[7:4]));
  endtask

  task automatic set_port(input int p, input logic dv, input logic [TW-1:0] t,
                          input logic [31:0] pc);
    v_valid[p]           = 1'b1;
    v_dev[p]             = dv;
    v_tag[p*TW +: TW]    = t;
    v_pc[p*32 +: 32]     = pc;
    v_bhsr[p*8 +: 8]     = pc[15:8];
    v_lpc[p*10 +: 10]    = pc[9:0];
    v_spc[p*10 +: 10]    = pc[19:10];
    v_lid[p*4 +: 4]      = pc[3:0];
    v_sid[p*4 +: 4]      = pc[7:4];
  endtask

  task automatic clear_ports();
    v_valid = '0;
    v_dev   = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with reports active
    set_port(0, 1'b0, 6'd10, 32'h000A_1234);
    set_port(1, 1'b1, 6'd5,  32'h0005_5678);
    ready = 1'b1;
    repeat (3) step();
    expect_out("rst_hold", 1'b0, 1'b0, 6'd0, 32'h0);
    clear_ports();
    ready = 1'b0;
    rst_n = 1'b1;
    step();
    expect_out("rst_rel", 1'b0, 1'b0, 6'd0, 32'h0);

    // Simultaneous reports: younger port0, older port1
    head = 6'd0; ready = 1'b1;
    set_port(0, 1'b0, 6'd10, 32'h0001_100A);
    set_port(1, 1'b0, 6'd5,  32'h0002_2005);
    step();
    expect_out("simul", 1'b1, 1'b0, 6'd5, 32'h0002_2005);
    clear_ports();
    step();
    expect_out("simul_done", 1'b0, 1'b0, 6'd0, 32'h0);

    // Wrap-around age
    head = 6'd60;
    set_port(0, 1'b0, 6'd62, 32'h0003_303E);
    set_port(1, 1'b0, 6'd2,  32'h0003_3102);
    step();
    expect_out("wrap", 1'b1, 1'b0, 6'd62, 32'h0003_303E);
    clear_ports();
    step();
    check_eq("wrap_done.ss", 64'(ss_o), 64'd0);

    // Backpressure with replacement
    head = 6'd0; ready = 1'b0;
    set_port(0, 1'b0, 6'd20, 32'h0004_4014);
    step();
    expect_out("bp_first", 1'b1, 1'b0, 6'd20, 32'h0004_4014);
    set_port(0, 1'b0, 6'd15, 32'h0004_500F);
    step();
    expect_out("bp_older", 1'b1, 1'b0, 6'd15, 32'h0004_500F);
    clear_ports();
    set_port(1, 1'b0, 6'd25, 32'h0004_6019);
    step();
    expect_out("bp_younger", 1'b1, 1'b0, 6'd15, 32'h0004_500F);
    clear_ports();
    ready = 1'b1;
    step();
    expect_out("bp_issue", 1'b0, 1'b0, 6'd0, 32'h0);
    step();
    check_eq("bp_once.ss", 64'(ss_o), 64'd0);

    // Flush discards younger pending; same-cycle older report survives
    ready = 1'b0;
    set_port(0, 1'b0, 6'd20, 32'h0005_7014);
    step();
    check_eq("fl_pend.tag", 64'(tag_o), 64'd20);
    clear_ports();
    flush = 1'b1; flush_tag = 6'd12;
    step();
    expect_out("fl_kill", 1'b0, 1'b0, 6'd0, 32'h0);
    flush = 1'b0;
    set_port(0, 1'b0, 6'd20, 32'h0005_7014);
    step();
    check_eq("fl_pend2.tag", 64'(tag_o), 64'd20);
    clear_ports();
    set_port(1, 1'b0, 6'd8, 32'h0005_8008);
    flush = 1'b1; flush_tag = 6'd12;
    step();
    expect_out("fl_capture", 1'b1, 1'b0, 6'd8, 32'h0005_8008);
    clear_ports();
    flush_tag = 6'd8;
    step();
    expect_out("fl_self", 1'b1, 1'b0, 6'd8, 32'h0005_8008);
    flush = 1'b0; ready = 1'b1;
    step();
    check_eq("fl_done.ss", 64'(ss_o), 64'd0);

    // Device violation
    ready = 1'b0;
    set_port(1, 1'b1, 6'd3, 32'h0006_9003);
    step();
    expect_out("dev", 1'b0, 1'b1, 6'd3, 32'h0006_9003);
    clear_ports();
    ready = 1'b1;
    step();
    check_eq("dev_done.dev", 64'(dev_o), 64'd0);

    // Age tie: lowest port wins; equal tag never replaces pending
    ready = 1'b0;
    set_port(0, 1'b0, 6'd7, 32'h0007_A007);
    set_port(1, 1'b0, 6'd7, 32'h0007_B107);
    step();
    check_eq("tie.pc", 64'(pc_o), 64'h0007_A007);
    clear_ports();
    set_port(1, 1'b0, 6'd7, 32'h0007_C207);
    step();
    check_eq("eq_keep.pc", 64'(pc_o), 64'h0007_A007);

    // Issue with older report in the same cycle captures it; younger is dropped
    clear_ports();
    set_port(0, 1'b0, 6'd4, 32'h0008_D004);
    ready = 1'b1;
    step();
    expect_out("iss_older", 1'b1, 1'b0, 6'd4, 32'h0008_D004);
    clear_ports();
    set_port(0, 1'b0, 6'd30, 32'h0008_E01E);
    step();
    expect_out("iss_younger", 1'b0, 1'b0, 6'd0, 32'h0);

    // Asynchronous reset mid-operation
    clear_ports();
    ready = 1'b0;
    set_port(0, 1'b0, 6'd11, 32'h0009_F00B);
    step();
    check_eq("arst_pend.ss", 64'(ss_o), 64'd1);
    clear_ports();
    #2 rst_n = 1'b0;
    #1;
    expect_out("arst", 1'b0, 1'b0, 6'd0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_eq("arst_rel.ss", 64'(ss_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lsu_violation_arbiter.md
# lsu_violation_arbiter

Parametrised memory-order violation arbiter between the load/store unit channels and the front-end/ROB redirect path. It accepts store-set and device violation reports from `NUM_PORTS` LSU channels in the same cycle and keeps the single oldest one, by ROB age, in a pending register. It presents that report to IF, ID and ROB with a valid/ready handshake. It drops reports made redundant by older violations or by external flushes.

## Interface
- `NUM_PORTS`, 2: number of LSU reporting channels (≥1)
- `ROB_TAG_W`, 6: ROB tag width; age arithmetic is modulo 2^ROB_TAG_W
- `PC_W`, 32: program counter width
- `BHSR_W`, 8: branch history width
- `SSIT_W`, 10: SSIT index width
- `LFST_W`, 4: LFST id width

- `clk` in 1: clock
- `rst_n` in 1: asynchronous active-low reset
- `viol_valid_i` in NUM_PORTS: per-port violation report
- `viol_device_i` in NUM_PORTS: report is a device violation (no store-set training)
- `viol_rob_tag_i` in NUM_PORTS*ROB_TAG_W: ROB tag of the violating load
- `viol_pc_i` in NUM_PORTS*PC_W: refetch PC
- `viol_bhsr_i` in NUM_PORTS*BHSR_W: branch history to restore
- `viol_load_pc_i`, `viol_store_pc_i` in NUM_PORTS*SSIT_W: SSIT indices
- `viol_load_id_i`, `viol_store_id_i` in NUM_PORTS*LFST_W: LFST ids
- `rob_head_i` in ROB_TAG_W: current ROB head tag
- `ext_flush_i` in 1: external flush (branch mispredict)
- `ext_flush_tag_i` in ROB_TAG_W: tag of the flushing instruction
- `redirect_ready_i` in 1: consumer accepts the pending report this cycle
- `store_set_violation_o` out 1: pending store-set violation
- `device_violation_o` out 1: pending device violation
- `store_set_rob_tag_o` out ROB_TAG_W: tag of the pending report
- `violation_pc_o` out PC_W; `violation_bhsr_o` out BHSR_W
- `violation_load_pc_o`, `violation_store_pc_o` out SSIT_W
- `violation_load_id_o`, `violation_store_id_o` out LFST_W

## Operation
- Age = (tag − rob_head_i) mod 2^ROB_TAG_W. A lower age is older. The age of the pending entry is recomputed every cycle from the current head.
- Candidate = the valid input with the lowest age. On an age tie, the lowest port index wins.
- Flush filter, applied to the candidate and to the pending entry: if `ext_flush_i` is high and age(x) > age(ext_flush_tag_i), x is discarded. The flushing instruction itself is kept.
- Issue = pending valid && `redirect_ready_i`.
- Next pending:
  - If issue: the filtered candidate is captured only if it is older than the issued entry; otherwise pending becomes empty.
  - If no issue: the filtered candidate replaces pending when pending is empty/discarded or the candidate is strictly older; otherwise pending is kept.
- Equal tags are never a replacement; the already-pending entry wins.
- Issue takes precedence over a flush that would kill the pending entry in the same cycle.
- `store_set_violation_o` = pending valid && !device. `device_violation_o` = pending valid && device. The two are never both high.

## Timing
- All outputs are registered. Every output resets to 0.
- Latency is 1 cycle from a report on an input to the outputs.
- While valid && !ready, the payload is held stable unless an older report replaces it or a flush discards it. Either change is visible the next cycle.
- An accepted report deasserts the next cycle unless a new older report was captured.
- When reset is asserted mid-operation, the pending report is lost immediately (asynchronous); no redirect is issued.

## Configuration
- `LSU_VIOL_STATS_EN` defined: adds outputs `viol_issue_cnt_o` and `viol_drop_cnt_o`, each 32 bits, saturating, reset to 0.
  - `viol_issue_cnt_o` increments on each issue.
  - `viol_drop_cnt_o` increments on each cycle in which at least one valid input report is not captured.
- Undefined: these ports and their counters are absent; behaviour is otherwise identical.

## Test plan
Configuration for all scenarios: NUM_PORTS=2, ROB_TAG_W=6.
- Reset: hold rst_n=0 with inputs active → all outputs 0. Release → outputs stay 0 until a report arrives.
- Simultaneous reports: head=0; port0 tag 10, port1 tag 5; ready=1 → next cycle `store_set_violation_o`=1, tag 5, port1 payload. The cycle after, outputs are 0.
- Wrap-around: head=60; port0 tag 62, port1 tag 2 → tag 62 is issued (age 2 vs 6).
- Backpressure/replacement: ready=0, pending tag 20 (head 0).
  - Input tag 15 → output changes to tag 15.
  - Input tag 25 → ignored.
  - ready=1 → tag 15 is issued exactly once.
- Flush: head=0, pending tag 20, ready=0; ext_flush tag 12 → outputs 0 next cycle. A same-cycle input tag 8 is captured and shown instead.
- Device violation: port1 tag 3 with device=1 → `device_violation_o`=1 and `store_set_violation_o`=0. With `LSU_VIOL_STATS_EN`, `viol_issue_cnt_o`=1 after acceptance.
